// File: rtl/cache_request_master.sv
// Core-side initiator for the ICache request port: one load/store in flight,
// local address checks, single-cycle en strobe and a bounded stall wait.
module cache_request_master #(
    parameter int WORD_ADDR_W = 27,
    parameter int TIMEOUT     = 4096,
    parameter int CNT_W       = 13
) (
    input  logic        clock,
    input  logic        cpu_reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rd,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd,
    input  logic        mem_stall,
    output logic        timeout_seen,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mem_en_nxt, mem_we_nxt, resp_valid_nxt, resp_err_nxt, timeout_seen_nxt;
    logic [31:0]      mem_wd_nxt, mem_addr_nxt, resp_rd_nxt;
    logic             addr_bad;

    // Both handshakes: a transfer happens on a rising edge where valid && ready;
    // the producer holds its payload until then, and response fields stay
    // frozen while resp_valid is high and resp_ready is low.
    assign req_ready = (state == IDLE) && !mem_stall;
    assign dbg_state = state;

    assign addr_bad = (req_addr[1:0] != 2'b00) ||
                      ((req_addr >> (WORD_ADDR_W + 2)) != 32'd0);

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        mem_en_nxt       = 1'b0;
        mem_we_nxt       = mem_we;
        mem_wd_nxt       = mem_wd;
        mem_addr_nxt     = mem_addr;
        resp_valid_nxt   = resp_valid;
        resp_rd_nxt      = resp_rd;
        resp_err_nxt     = resp_err;
        timeout_seen_nxt = timeout_seen;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (addr_bad) begin
                        resp_err_nxt   = 1'b1;
                        resp_rd_nxt    = 32'd0;
                        resp_valid_nxt = 1'b1;
                        state_nxt      = RESP;
                    end else begin
                        mem_we_nxt   = req_we;
                        mem_wd_nxt   = req_wd;
                        mem_addr_nxt = {{(32 - WORD_ADDR_W){1'b0}}, req_addr[WORD_ADDR_W+1:2]};
                        mem_en_nxt   = 1'b1;
                        state_nxt    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A release on the last allowed cycle still counts as a completion.
                if (!mem_stall) begin
                    resp_rd_nxt    = mem_we ? 32'd0 : mem_rd;
                    resp_err_nxt   = 1'b0;
                    resp_valid_nxt = 1'b1;
                    state_nxt      = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    resp_rd_nxt      = 32'd0;
                    resp_err_nxt     = 1'b1;
                    resp_valid_nxt   = 1'b1;
                    timeout_seen_nxt = 1'b1;
                    state_nxt        = RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_wd       <= 32'd0;
            mem_addr     <= 32'd0;
            resp_valid   <= 1'b0;
            resp_rd      <= 32'd0;
            resp_err     <= 1'b0;
            timeout_seen <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            mem_en       <= mem_en_nxt;
            mem_we       <= mem_we_nxt;
            mem_wd       <= mem_wd_nxt;
            mem_addr     <= mem_addr_nxt;
            resp_valid   <= resp_valid_nxt;
            resp_rd      <= resp_rd_nxt;
            resp_err     <= resp_err_nxt;
            timeout_seen <= timeout_seen_nxt;
        end
    end

endmodule

// File: tb/tb_cache_request_master.sv
// Bench for cache_request_master: directed and random transactions checked
// against a transaction-level model of latency, data, errors and sticky state.
module tb_cache_request_master;

    localparam int TIMEOUT     = 8;
    localparam int WORD_ADDR_W = 27;
    localparam int CNT_W       = 4;

    logic        clock;
    logic        cpu_reset_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wd;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rd;
    logic        mem_en, mem_we, mem_stall, timeout_seen;
    logic [31:0] mem_wd, mem_addr, mem_rd;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        exp_to;
    logic [31:0] exp_mem_addr, exp_mem_wd;
    logic        exp_mem_we;

    cache_request_master #(
        .WORD_ADDR_W(WORD_ADDR_W),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clock       (clock),
        .cpu_reset_n (cpu_reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wd      (req_wd),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rd     (resp_rd),
        .resp_err    (resp_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_wd      (mem_wd),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_stall   (mem_stall),
        .timeout_seen(timeout_seen),
        .dbg_state   (dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_to       = 1'b0;
        exp_mem_addr = 32'd0;
        exp_mem_wd   = 32'd0;
        exp_mem_we   = 1'b0;
    endtask

    // One request end to end; stall_n = stalled cycles after ISSUE, hold_n =
    // cycles resp_ready stays low once the response shows up.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input int stall_n, input logic [31:0] rd_val, input int hold_n);
        logic        bad, timed_out, exp_err, got_resp, stable_ok, blocked_ok, started;
        logic [31:0] exp_rd, snap_rd;
        int          exp_lat, en_cnt, stall_left, resp_at;

        bad       = (addr % 4 != 0) || (64'(addr) >= (64'd1 << (WORD_ADDR_W + 2)));
        timed_out = !bad && (stall_n >= TIMEOUT);
        exp_err   = bad || timed_out;
        exp_rd    = (exp_err || we) ? 32'd0 : rd_val;
        exp_lat   = bad ? 1 : (timed_out ? TIMEOUT + 2 : stall_n + 3);

        @(negedge clock);
        mem_stall = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wd    = wd;
        #1 check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        if (!bad) begin
            exp_mem_addr = addr / 4;
            exp_mem_we   = we;
            exp_mem_wd   = wd;
        end
        if (timed_out) exp_to = 1'b1;

        en_cnt = 0; stall_left = 0; got_resp = 1'b0; resp_at = 0; started = 1'b0;
        for (int i = 1; i <= exp_lat + 20 && !got_resp; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                got_resp = 1'b1;
                resp_at  = i;
            end
            if (mem_en) begin
                en_cnt++;
                check_eq("en_addr", mem_addr, addr / 4);
                check_eq("en_we", {31'd0, mem_we}, {31'd0, we});
                check_eq("en_wd", mem_wd, wd);
                stall_left = stall_n;
                started    = 1'b1;
                mem_stall  = 1'b0;
            end else if (started) begin
                mem_stall = (stall_left > 0);
                if (stall_left > 0) stall_left--;
                mem_rd = mem_stall ? $urandom : rd_val;
            end
            // Requests presented while busy must be ignored.
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_we    = 1'($urandom_range(0, 1));
            req_wd    = $urandom;
        end

        check_eq("resp_latency", resp_at, exp_lat);
        check_eq("resp_rd", resp_rd, exp_rd);
        check_eq("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        check_eq("timeout_seen", {31'd0, timeout_seen}, {31'd0, exp_to});
        check_eq("mem_addr_hold", mem_addr, exp_mem_addr);
        check_eq("mem_we_hold", {31'd0, mem_we}, {31'd0, exp_mem_we});
        check_eq("mem_wd_hold", mem_wd, exp_mem_wd);

        snap_rd   = resp_rd;
        stable_ok = 1'b1;
        for (int h = 0; h < hold_n; h++) begin
            @(negedge clock);
            if (!resp_valid || resp_rd !== snap_rd || resp_err !== exp_err || req_ready || mem_en)
                stable_ok = 1'b0;
            mem_stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            mem_rd = $urandom;
        end
        if (hold_n > 0) check_eq("resp_hold_stable", {31'd0, stable_ok}, 32'd1);

        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(negedge clock);
        resp_ready = 1'b0;
        check_eq("resp_valid_cleared", {31'd0, resp_valid}, 32'd0);
        check_eq("state_idle", {30'd0, dbg_state}, 32'd0);
        check_eq("en_pulses", en_cnt, bad ? 0 : 1);

        if (mem_stall) begin
            check_eq("ready_low_stall", {31'd0, req_ready}, 32'd0);
            blocked_ok = 1'b1;
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_addr   = 32'h0000_0100;
            repeat (3) begin
                @(negedge clock);
                if (mem_en || req_ready || dbg_state != 2'd0) blocked_ok = 1'b0;
            end
            check_eq("no_issue_while_stall", {31'd0, blocked_ok}, 32'd1);
            req_valid = 1'b0;
            mem_stall = 1'b0;
        end
        #1 check_eq("ready_after_resp", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic reset_mid_wait();
        @(negedge clock);
        mem_stall = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0040;
        req_wd    = 32'hA5A5_0001;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        mem_stall = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("pre_reset_wait", {30'd0, dbg_state}, 32'd2);
        #2 cpu_reset_n = 1'b0;
        #1;
        check_eq("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
        check_eq("rst_timeout_seen", {31'd0, timeout_seen}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_wd", mem_wd, 32'd0);
        model_reset();
        repeat (2) @(negedge clock);
        cpu_reset_n = 1'b1;
        mem_stall   = 1'b0;
        @(negedge clock);
        check_eq("post_rst_state", {30'd0, dbg_state}, 32'd0);
        check_eq("post_rst_timeout_seen", {31'd0, timeout_seen}, 32'd0);
        check_eq("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        cpu_reset_n = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'd0;
        req_wd      = 32'd0;
        resp_ready  = 1'b0;
        mem_rd      = 32'd0;
        mem_stall   = 1'b0;
        model_reset();

        repeat (2) @(negedge clock);
        check_eq("reset_mem_en", {31'd0, mem_en}, 32'd0);
        check_eq("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("reset_resp_rd", resp_rd, 32'd0);
        check_eq("reset_mem_addr", mem_addr, 32'd0);
        check_eq("reset_timeout_seen", {31'd0, timeout_seen}, 32'd0);
        cpu_reset_n = 1'b1;
        @(negedge clock);
        check_eq("reset_state", {30'd0, dbg_state}, 32'd0);

        run_txn(1'b0, 32'h0000_1000, 32'h0, 5, 32'hDEAD_BEEF, 0);
        run_txn(1'b1, 32'h0000_0008, 32'h1234_5678, 0, 32'h5555_AAAA, 0);
        run_txn(1'b0, 32'h0000_0002, 32'h0, 0, 32'h1111_1111, 0);
        run_txn(1'b0, 32'h2000_0000, 32'h0, 0, 32'h2222_2222, 0);
        run_txn(1'b0, 32'h1FFF_FFFC, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D, 0);
        run_txn(1'b0, 32'h0000_0200, 32'h0, 1000, 32'h3333_3333, 0);
        run_txn(1'b0, 32'h0000_0300, 32'h0, 2, 32'h0BAD_F00D, 10);
        run_txn(1'b1, 32'h0000_0304, 32'h7777_0000, 0, 32'h0, 0);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       a = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
                1:       a = {3'b000, 27'($urandom), 2'($urandom_range(1, 3))};
                2:       a = 32'h2000_0000 | $urandom;
                default: a = 32'h1FFF_FF00 + 4 * $urandom_range(0, 63);
            endcase
            run_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, TIMEOUT + 3),
                    $urandom, $urandom_range(0, 3));
        end

        reset_mid_wait();
        run_txn(1'b0, 32'h0000_0010, 32'h0, 1, 32'h0123_4567, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
